// File: rtl/rx_lane_word_packer.sv
// Multi-lane 8b/10b word packer: per-lane byte-to-word assembly into small buffers,
// merged by a round-robin arbiter into one ready/valid output with per-lane error counters.

module rx_lane_sat_cnt #(
  parameter int CW = 8
) (
  input  logic          WCLK,
  input  logic          RESET,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] cnt
);
  always_ff @(posedge WCLK) begin
    if (RESET || clear)        cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end
endmodule

module rx_lane_word_packer_lane #(
  parameter int BPW   = 3,
  parameter int WPF   = 2,
  parameter int DEPTH = 4,
  parameter int CW    = 8,
  localparam int DW   = 8*BPW+1
) (
  input  logic          WCLK,
  input  logic          RESET,
  input  logic          enable,
  input  logic          sym_valid,
  input  logic          sym_k,
  input  logic [7:0]    sym_data,
  input  logic          sym_err,
  input  logic          clear_cnt,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          not_empty,
  output logic [CW-1:0] dec_cnt,
  output logic [CW-1:0] lost_cnt,
  output logic [CW-1:0] frame_cnt
);
  localparam int BW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int WW = (WPF > 1) ? $clog2(WPF) : 1;
  localparam int AW = $clog2(DEPTH);

  logic [BW-1:0]      byte_idx;
  logic [WW-1:0]      word_idx;
  logic [8*BPW-1:0]   word_sr, word_nxt;
  logic [DW-1:0]      mem [DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic               accept, is_data, last_byte, push, full, frame_abort;

  assign accept      = sym_valid & enable;
  assign is_data     = accept & ~sym_k;
  assign last_byte   = (byte_idx == BW'(BPW-1));
  assign push        = is_data & last_byte;
  // Newest byte enters at the bottom, so the first byte ends up most significant.
  assign word_nxt    = (8*BPW)'({word_sr, sym_data});
  assign full        = ((wr_ptr - rd_ptr) == (AW+1)'(DEPTH));
  assign not_empty   = (wr_ptr != rd_ptr);
  assign head        = mem[rd_ptr[AW-1:0]];
  assign frame_abort = accept & sym_k & ((byte_idx != '0) | (word_idx != '0));

  always_ff @(posedge WCLK) begin
    if (RESET) begin
      byte_idx <= '0;
      word_idx <= '0;
      word_sr  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (!enable || (accept && sym_k)) begin
        byte_idx <= '0;
        word_idx <= '0;
      end else if (is_data) begin
        word_sr <= word_nxt;
        if (last_byte) begin
          byte_idx <= '0;
          word_idx <= (word_idx == WW'(WPF-1)) ? '0 : word_idx + 1'b1;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
      // Fullness is the pre-pop state: a push into a full buffer drops even on a pop cycle.
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop)           rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge WCLK) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= {word_idx == '0, word_nxt};
  end

  rx_lane_sat_cnt #(.CW(CW)) u_dec (
    .WCLK(WCLK), .RESET(RESET), .clear(clear_cnt), .inc(accept & sym_err), .cnt(dec_cnt));
  rx_lane_sat_cnt #(.CW(CW)) u_lost (
    .WCLK(WCLK), .RESET(RESET), .clear(clear_cnt), .inc(push & full), .cnt(lost_cnt));
  rx_lane_sat_cnt #(.CW(CW)) u_frame (
    .WCLK(WCLK), .RESET(RESET), .clear(clear_cnt), .inc(frame_abort), .cnt(frame_cnt));
endmodule

module rx_lane_word_packer #(
  parameter int NUM_LANES       = 4,
  parameter int BYTES_PER_WORD  = 3,
  parameter int WORDS_PER_FRAME = 2,
  parameter int BUF_DEPTH       = 4,
  parameter int CNT_WIDTH       = 8,
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                           WCLK,
  input  logic                           RESET,
  input  logic [NUM_LANES-1:0]           ENABLE,
  input  logic [NUM_LANES-1:0]           SYM_VALID,
  input  logic [NUM_LANES-1:0]           SYM_K,
  input  logic [8*NUM_LANES-1:0]         SYM_DATA,
  input  logic [NUM_LANES-1:0]           SYM_ERR,
  input  logic                           CLEAR_CNT,
  output logic                           OUT_VALID,
  input  logic                           OUT_READY,
  output logic [8*BYTES_PER_WORD:0]      OUT_DATA,
  output logic [LW-1:0]                  OUT_LANE,
  output logic [CNT_WIDTH*NUM_LANES-1:0] DECODER_ERR_CNT,
  output logic [CNT_WIDTH*NUM_LANES-1:0] LOST_ERR_CNT,
  output logic [CNT_WIDTH*NUM_LANES-1:0] FRAME_ERR_CNT
);
  localparam int DW = 8*BYTES_PER_WORD+1;

  logic [NUM_LANES-1:0][DW-1:0] head;
  logic [NUM_LANES-1:0]         not_empty, pop;
  logic [LW-1:0]                last_gnt, gnt;
  logic                         gnt_vld, load;
  int                           rr_idx;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    rx_lane_word_packer_lane #(
      .BPW(BYTES_PER_WORD), .WPF(WORDS_PER_FRAME), .DEPTH(BUF_DEPTH), .CW(CNT_WIDTH)
    ) u_lane (
      .WCLK      (WCLK),
      .RESET     (RESET),
      .enable    (ENABLE[l]),
      .sym_valid (SYM_VALID[l]),
      .sym_k     (SYM_K[l]),
      .sym_data  (SYM_DATA[8*l +: 8]),
      .sym_err   (SYM_ERR[l]),
      .clear_cnt (CLEAR_CNT),
      .pop       (pop[l]),
      .head      (head[l]),
      .not_empty (not_empty[l]),
      .dec_cnt   (DECODER_ERR_CNT[CNT_WIDTH*l +: CNT_WIDTH]),
      .lost_cnt  (LOST_ERR_CNT[CNT_WIDTH*l +: CNT_WIDTH]),
      .frame_cnt (FRAME_ERR_CNT[CNT_WIDTH*l +: CNT_WIDTH])
    );
  end

  assign load = !OUT_VALID || OUT_READY;

  // Search starts one past the last grant, so every non-empty lane is reached within NUM_LANES grants.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = last_gnt;
    rr_idx  = 0;
    for (int i = 1; i <= NUM_LANES; i++) begin
      rr_idx = (int'(last_gnt) + i) % NUM_LANES;
      if (!gnt_vld && not_empty[LW'(rr_idx)]) begin
        gnt_vld = 1'b1;
        gnt     = LW'(rr_idx);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (load && gnt_vld) pop[gnt] = 1'b1;
  end

  always_ff @(posedge WCLK) begin
    if (RESET) begin
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_LANE  <= '0;
      last_gnt  <= LW'(NUM_LANES-1);
    end else if (load) begin
      OUT_VALID <= gnt_vld;
      if (gnt_vld) begin
        OUT_DATA <= head[gnt];
        OUT_LANE <= gnt;
        last_gnt <= gnt;
      end
    end
  end
endmodule

// File: tb/tb_rx_lane_word_packer.sv
// Directed bench for rx_lane_word_packer: queue-based reference model compared every cycle,
// plus hand-computed literal expectations for each scenario.

module tb_rx_lane_word_packer;
  localparam int NL = 4, BPW = 3, WPF = 2, DEPTH = 4, CW = 8, DW = 25, LW = 2;

  logic            WCLK = 1'b0;
  logic            RESET;
  logic [NL-1:0]   ENABLE, SYM_VALID, SYM_K, SYM_ERR;
  logic [8*NL-1:0] SYM_DATA;
  logic            CLEAR_CNT, OUT_VALID, OUT_READY;
  logic [DW-1:0]   OUT_DATA;
  logic [LW-1:0]   OUT_LANE;
  logic [CW*NL-1:0] DECODER_ERR_CNT, LOST_ERR_CNT, FRAME_ERR_CNT;

  rx_lane_word_packer #(
    .NUM_LANES(NL), .BYTES_PER_WORD(BPW), .WORDS_PER_FRAME(WPF), .BUF_DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .WCLK(WCLK), .RESET(RESET), .ENABLE(ENABLE), .SYM_VALID(SYM_VALID), .SYM_K(SYM_K),
    .SYM_DATA(SYM_DATA), .SYM_ERR(SYM_ERR), .CLEAR_CNT(CLEAR_CNT), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_LANE(OUT_LANE),
    .DECODER_ERR_CNT(DECODER_ERR_CNT), .LOST_ERR_CNT(LOST_ERR_CNT), .FRAME_ERR_CNT(FRAME_ERR_CNT)
  );

  always #5 WCLK = ~WCLK;

  int n_vec = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lane queues, byte/word counts, integer counters.
  logic [DW-1:0] mq [NL][$];
  int            bc [NL], wc [NL], dec [NL], lost [NL], frm [NL];
  logic [31:0]   acc [NL];
  bit            full_b [NL];
  bit            m_valid, armed = 0, got;
  logic [DW-1:0] m_data;
  int            m_lane, m_last, c;

  function automatic int sat(input int v);
    return (v < 255) ? v + 1 : v;
  endfunction

  always @(posedge WCLK) begin
    if (RESET) begin
      for (int l = 0; l < NL; l++) begin
        mq[l].delete();
        bc[l] = 0; wc[l] = 0; dec[l] = 0; lost[l] = 0; frm[l] = 0; acc[l] = 0;
      end
      m_valid = 0; m_data = '0; m_lane = 0; m_last = NL-1; armed = 1;
    end else begin
      for (int l = 0; l < NL; l++) full_b[l] = (mq[l].size() == DEPTH);
      if (!m_valid || OUT_READY) begin
        got = 0;
        for (int i = 1; i <= NL; i++) begin
          c = (m_last + i) % NL;
          if (!got && mq[c].size() > 0) begin
            got = 1; m_data = mq[c].pop_front(); m_lane = c; m_last = c;
          end
        end
        m_valid = got;
      end
      for (int l = 0; l < NL; l++) begin
        if (!ENABLE[l]) begin
          bc[l] = 0; wc[l] = 0;
        end else if (SYM_VALID[l]) begin
          if (SYM_ERR[l]) dec[l] = sat(dec[l]);
          if (SYM_K[l]) begin
            if (bc[l] != 0 || wc[l] != 0) frm[l] = sat(frm[l]);
            bc[l] = 0; wc[l] = 0;
          end else begin
            acc[l] = (acc[l] << 8) | 32'(SYM_DATA[8*l +: 8]);
            bc[l]++;
            if (bc[l] == BPW) begin
              if (full_b[l]) lost[l] = sat(lost[l]);
              else mq[l].push_back({wc[l] == 0, acc[l][8*BPW-1:0]});
              bc[l] = 0;
              wc[l] = (wc[l] + 1) % WPF;
            end
          end
        end
      end
      if (CLEAR_CNT)
        for (int l = 0; l < NL; l++) begin dec[l] = 0; lost[l] = 0; frm[l] = 0; end
    end
  end

  always @(negedge WCLK) begin
    if (armed) begin
      check("out_valid", OUT_VALID, m_valid);
      if (m_valid) begin
        check("out_data", OUT_DATA, m_data);
        check("out_lane", OUT_LANE, m_lane);
      end
      for (int l = 0; l < NL; l++) begin
        check("dec_cnt", DECODER_ERR_CNT[8*l +: 8], dec[l]);
        check("lost_cnt", LOST_ERR_CNT[8*l +: 8], lost[l]);
        check("frame_cnt", FRAME_ERR_CNT[8*l +: 8], frm[l]);
      end
    end
  end

  task automatic tick();
    @(posedge WCLK); #1;
  endtask

  task automatic sym(input int l, input bit k, input logic [7:0] d, input bit e = 0);
    SYM_VALID[l] = 1'b1; SYM_K[l] = k; SYM_DATA[8*l +: 8] = d; SYM_ERR[l] = e;
    tick();
    SYM_VALID[l] = 1'b0; SYM_K[l] = 1'b0; SYM_ERR[l] = 1'b0;
  endtask

  task automatic word_all(input logic [7:0] base);
    for (int j = 0; j < BPW; j++) begin
      for (int l = 0; l < NL; l++) SYM_DATA[8*l +: 8] = base + 8'(16*l + j);
      SYM_VALID = '1;
      tick();
    end
    SYM_VALID = '0;
  endtask

  task automatic do_reset();
    RESET = 1'b1; tick(); RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; ENABLE = '1; SYM_VALID = '0; SYM_K = '0; SYM_ERR = '0; SYM_DATA = '0;
    CLEAR_CNT = 1'b0; OUT_READY = 1'b1;
    tick(); tick();
    check("reset_valid", OUT_VALID, 1'b0);
    check("reset_data", OUT_DATA, 25'h0);
    RESET = 1'b0;

    // Basic packing on lane 0
    sym(0, 1, 8'hBC);
    sym(0, 0, 8'h11); sym(0, 0, 8'h22); sym(0, 0, 8'h33);
    tick();
    check("basic_w0", OUT_DATA, 25'h1112233);
    check("basic_w0_lane", OUT_LANE, 2'd0);
    sym(0, 0, 8'h44); sym(0, 0, 8'h55); sym(0, 0, 8'h66);
    tick();
    check("basic_w1", OUT_DATA, 25'h0445566);
    tick(); tick();
    check("basic_cnts", {DECODER_ERR_CNT, LOST_ERR_CNT, FRAME_ERR_CNT}, 64'h0);

    // Truncated frame on lane 1
    sym(1, 0, 8'h11); sym(1, 0, 8'h22); sym(1, 0, 8'h33); sym(1, 0, 8'h44);
    sym(1, 1, 8'hBC);
    sym(1, 0, 8'hAA); sym(1, 0, 8'hBB); sym(1, 0, 8'hCC);
    tick();
    check("trunc_w0", OUT_DATA, 25'h1AABBCC);
    sym(1, 0, 8'hDD); sym(1, 0, 8'hEE); sym(1, 0, 8'hFF);
    tick();
    check("trunc_w1", OUT_DATA, 25'h0DDEEFF);
    tick(); tick();
    check("trunc_frame_cnt", FRAME_ERR_CNT[15:8], 8'd1);

    // Overflow: output register held by a lane-1 word, lane 2 sends 6 words
    OUT_READY = 1'b0;
    sym(1, 0, 8'h01); sym(1, 0, 8'h02); sym(1, 0, 8'h03);
    tick();
    check("stall_data", OUT_DATA, 25'h1010203);
    for (int i = 0; i < 6*BPW; i++) sym(2, 0, 8'h20 + 8'(i));
    check("ovf_lost", LOST_ERR_CNT[23:16], 8'd2);
    check("stall_hold", OUT_DATA, 25'h1010203);
    check("stall_lane", OUT_LANE, 2'd1);
    OUT_READY = 1'b1;
    tick();
    check("ovf_first", OUT_DATA, 25'h1202122);
    tick(); tick(); tick(); tick();
    check("ovf_drained", OUT_VALID, 1'b0);

    // Round-robin after reset: 0,1,2,3 twice
    do_reset();
    for (int r = 0; r < 2; r++) begin
      word_all(8'h80 + 8'(r));
      for (int l = 0; l < NL; l++) begin
        tick();
        check("rr_lane", OUT_LANE, l);
      end
    end

    // Decoder error saturation and clear priority
    for (int i = 0; i < 300; i++) sym(3, 1, 8'hBC, 1);
    check("dec_sat", DECODER_ERR_CNT[31:24], 8'd255);
    CLEAR_CNT = 1'b1;
    sym(3, 1, 8'hBC, 1);
    CLEAR_CNT = 1'b0;
    check("dec_clear", DECODER_ERR_CNT[31:24], 8'd0);

    // Enable drop mid-frame
    sym(0, 0, 8'h01); sym(0, 0, 8'h02);
    ENABLE[0] = 1'b0; tick(); ENABLE[0] = 1'b1;
    sym(0, 0, 8'h0A); sym(0, 0, 8'h0B); sym(0, 0, 8'h0C);
    tick();
    check("en_word", OUT_DATA, 25'h10A0B0C);
    check("en_frame_cnt", FRAME_ERR_CNT[7:0], 8'd0);

    // Reset while the output is stalled
    OUT_READY = 1'b0;
    for (int i = 0; i < 2*BPW; i++) sym(1, 0, 8'h50 + 8'(i));
    tick();
    check("pre_rst_valid", OUT_VALID, 1'b1);
    do_reset();
    check("rst_valid", OUT_VALID, 1'b0);
    OUT_READY = 1'b1;
    tick(); tick(); tick();
    check("rst_empty", OUT_VALID, 1'b0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/rx_lane_word_packer.md
# rx_lane_word_packer

Multi-lane successor to the single-lane 8b/10b receiver word assembly. It takes already-decoded symbol streams from `NUM_LANES` receivers and packs data bytes into `BYTES_PER_WORD` words, tagging frame boundaries and discarding frames that a comma truncates. Each lane has a small word buffer, and a round-robin arbiter merges the buffers into one ready/valid output that feeds the readout FIFO. Per-lane saturating counters track decoder errors, lost words and truncated frames.

## Interface
- `NUM_LANES`, 4: number of receiver lanes (1..8).
- `BYTES_PER_WORD`, 3: data bytes per output word (1..4).
- `WORDS_PER_FRAME`, 2: words per chip frame (1..4).
- `BUF_DEPTH`, 4: words per lane buffer (power of 2, ≥2).
- `CNT_WIDTH`, 8: width of each error counter.
- `LW` is a derived value, not a parameter: max(1, clog2(NUM_LANES)).

Ports (one clock, `WCLK`; reset is synchronous and active-high, `RESET`):
- `WCLK`  in  1  clock for all logic.
- `RESET`  in  1  synchronous, active-high reset.
- `ENABLE`  in  NUM_LANES  per-lane receive enable.
- `SYM_VALID`  in  NUM_LANES  decoded symbol present this cycle.
- `SYM_K`  in  NUM_LANES  symbol is a K (control) character.
- `SYM_DATA`  in  8*NUM_LANES  decoded byte; lane l uses bits [8l+7:8l].
- `SYM_ERR`  in  NUM_LANES  code or disparity error on this symbol.
- `CLEAR_CNT`  in  1  synchronous clear of all counters.
- `OUT_VALID`  out  1  output word valid.
- `OUT_READY`  in  1  consumer accepts the word.
- `OUT_DATA`  out  8*BYTES_PER_WORD+1  bit MSB = first-word-of-frame flag; remaining bits = word, first byte received in the most significant byte.
- `OUT_LANE`  out  LW  source lane of `OUT_DATA`.
- `DECODER_ERR_CNT`  out  CNT_WIDTH*NUM_LANES  per-lane saturating count of error symbols.
- `LOST_ERR_CNT`  out  CNT_WIDTH*NUM_LANES  per-lane saturating count of words dropped because the buffer was full.
- `FRAME_ERR_CNT`  out  CNT_WIDTH*NUM_LANES  per-lane saturating count of truncated frames.

## Operation
- **Accepted symbol:** a symbol on lane l is accepted when `SYM_VALID[l] && ENABLE[l]`. Symbols that are not accepted have no effect.
- **Per-lane state:** `byte_idx` (0..BYTES_PER_WORD-1), `word_idx` (0..WORDS_PER_FRAME-1), and a word shift register.
- **Data symbol:**
  - The byte is stored at slot `byte_idx`.
  - If `byte_idx == BYTES_PER_WORD-1`, the word is complete:
    - Push `{word_idx==0, word}` to the lane buffer.
    - Set `byte_idx` to 0.
    - `word_idx` increments modulo `WORDS_PER_FRAME`.
  - Otherwise `byte_idx` increments.
- **K symbol:**
  - Not stored.
  - Clears `byte_idx` and `word_idx`.
  - If either was nonzero, the partial frame is abandoned and `FRAME_ERR_CNT[l]` increments. Words of that frame already pushed stay in the buffer.
- **Decoder error:** an accepted symbol with `SYM_ERR` increments `DECODER_ERR_CNT[l]`. The symbol is still processed normally as data or K.
- **Enable low:** `ENABLE[l]` low clears `byte_idx` and `word_idx` with no counting. Buffer contents are kept and still drain.
- **Push to full buffer:** the word is dropped and `LOST_ERR_CNT[l]` increments. Fullness is evaluated before any same-cycle pop, so a push to a buffer that is full at that edge is dropped even if a pop occurs in the same cycle.
- **Counters:** all counters saturate at 2^CNT_WIDTH-1. `CLEAR_CNT` zeroes all counters and takes priority over a same-cycle increment.
- **Arbiter:**
  - Round-robin over non-empty lane buffers.
  - The search starts at the lane after the last granted lane.
  - After reset, lane 0 has first priority.
- **Output register:**
  - Loads when empty, or when a transfer (`OUT_VALID && OUT_READY`) occurs that cycle. This allows one word per cycle.
  - While `OUT_VALID && !OUT_READY`, `OUT_DATA` and `OUT_LANE` hold stable.

## Timing
- **Reset values:**
  - `OUT_VALID`, `OUT_DATA`, `OUT_LANE` and all counters are 0.
  - All buffers are empty; all `byte_idx` and `word_idx` are 0; the round-robin pointer is set so lane 0 wins first.
- **Reset during a transfer:** reset mid-frame or mid-transfer discards everything, with no counting.
- **Latency:**
  - The completing symbol is sampled at edge n.
  - The word is in the buffer after edge n.
  - The output register loads at edge n+1, so `OUT_VALID` is high after edge n+1 when the output is free and no other lane wins.
- **Throughput:** 1 word per cycle total. Each lane accepts 1 symbol per cycle.
- **Same-cycle K and word completion:** impossible, because these are separate symbols.
- **Counter update:** a counter increments in the cycle after its event is sampled.

## Test plan
- **Basic packing:** defaults, lane 0 receives K, then bytes 11 22 33 44 55 66 -> output `1_112233` (lane 0), then `0_445566`, each 2 cycles after its completing byte; no counters increment.
- **Truncated frame:** lane 1 receives 11 22 33 44, K, then 6 fresh bytes AA–FF -> `1_112233` output; `FRAME_ERR_CNT[1]=1`; next frame `1_AABBCC`, `0_DDEEFF`; partial 44 discarded.
- **Buffer overflow:** `OUT_READY=0`, lane 2 sends 6 full words -> 4 stored, `LOST_ERR_CNT[2]=2`; raise `OUT_READY` -> exactly 4 words out in order.
- **Round-robin fairness:** all 4 lanes complete a word on the same cycle with `OUT_READY=1` -> lanes output in order 0,1,2,3 on consecutive cycles; repeat -> order continues from the last granted lane and stays fair.
- **Errors and saturation:** 300 `SYM_ERR` symbols on lane 3 -> `DECODER_ERR_CNT[3]=255`; then `CLEAR_CNT` together with one more error -> 0.
- **Enable and reset mid-frame:** `ENABLE[0]` dropped after 2 bytes, then re-enabled with 3 bytes -> one word of those 3 bytes with first flag=1, `FRAME_ERR_CNT[0]=0`; `RESET` during a stalled output -> `OUT_VALID=0` next cycle and buffers empty.
